// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU-side types; ramstate_t encodes the RAM status bus.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: memory arbiter FSM state encoding.
package diaosi_types_pkg;
    typedef enum logic [1:0] {IDLE, DACC, IACC, ERR} arb_state_t;
endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between instruction fetch and data ports.
// Ports: CLK/nRST (async active-low); iREN/iaddr and dREN/dWEN/daddr/dstore requests;
// halt blocks new fetch grants; ihit/iload and dhit/dload completions; ramREN/ramWEN/
// ramaddr/ramstore drive the RAM, ramload/ramstate return from it; err is sticky.
module memory_arbiter
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          dreq, access, fault;

    assign dreq   = dREN | dWEN;
    assign access = ramstate == ACCESS;
    assign fault  = ramstate == ERROR || wait_q == WW'(TIMEOUT);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        wait_d   = wait_q;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        err      = 1'b0;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (!iREN) starve_d = '0;
                // The starvation guard only yields to fetch when fetch can actually be granted,
                // otherwise a halted pipeline would lock out data forever.
                if (dreq && (starve_q < SW'(STARVE_MAX) || !iREN || halt)) begin
                    state_d = DACC;
                    if (iREN && starve_q < SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
                end else if (iREN && !halt) begin
                    state_d  = IACC;
                    starve_d = '0;
                end
            end
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (access) begin
                    dhit    = dreq;
                    dload   = dreq ? ramload : '0;
                    state_d = IDLE;
                end else if (fault) state_d = ERR;
                else wait_d = wait_q + 1'b1;
            end
            IACC: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (access) begin
                    ihit    = iREN;
                    iload   = iREN ? ramload : '0;
                    state_d = IDLE;
                end else if (fault) state_d = ERR;
                else wait_d = wait_q + 1'b1;
            end
            ERR: err = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of grant order, latency, timeout and reset behaviour.
module tb_memory_arbiter;
    logic        CLK = 1'b0, nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, halt = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = 2'd0;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    int passed = 0, total = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .halt(halt), .ihit(ihit), .iload(iload),
        .dhit(dhit), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task test_reset();
        @(negedge CLK); #1;
        total++;
        if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0 || ramaddr !== 0 || ramstore !== 0 || iload !== 0 || dload !== 0)
            $display("FAIL reset: hits/strobes/err %b addr %h store %h, want all 0", {ihit, dhit, ramREN, ramWEN, err}, ramaddr, ramstore);
        else passed++;
        @(negedge CLK); nRST = 1'b1;
    endtask

    task test_ifetch();
        @(negedge CLK); iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
        @(negedge CLK); #1;
        total++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || ihit !== 1'b0)
            $display("FAIL ifetch_busy1: ramREN %b addr %h ihit %b, want 1 40 0", ramREN, ramaddr, ihit);
        else passed++;
        @(negedge CLK); #1;
        total++;
        if (ramREN !== 1'b1 || ihit !== 1'b0) $display("FAIL ifetch_busy2: ramREN %b ihit %b, want 1 0", ramREN, ihit);
        else passed++;
        @(negedge CLK); ramstate = ACCESS; ramload = 32'h8C220004; #1;
        total++;
        if (ihit !== 1'b1 || iload !== 32'h8C220004 || dhit !== 1'b0)
            $display("FAIL ifetch_hit: ihit %b iload %h dhit %b, want 1 8c220004 0", ihit, iload, dhit);
        else passed++;
        @(negedge CLK); iREN = 1'b0; ramstate = FREE; #1;
        total++;
        if (ihit !== 1'b0 || ramREN !== 1'b0 || iload !== 0)
            $display("FAIL ifetch_after: ihit %b ramREN %b iload %h, want 0 0 0", ihit, ramREN, iload);
        else passed++;
    endtask

    task test_priority();
        logic [7:0] seq;
        int n;
        seq = '0;
        n = 0;
        @(negedge CLK); iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; iaddr = 32'h44; ramstate = ACCESS;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge CLK); ramload = 32'hA0000000 + c; #1;
            if (dhit) begin
                total++;
                if (dload !== ramload || ramaddr !== 32'h100 || ramREN !== 1'b1)
                    $display("FAIL prio_dload: dload %h addr %h ramREN %b, want %h 100 1", dload, ramaddr, ramREN, ramload);
                else passed++;
                seq[7-n] = 1'b1;
                n++;
            end else if (ihit) n++;
        end
        total++;
        if (n !== 8 || seq !== 8'b11101110) $display("FAIL prio_order: %0d grants pattern %b, want 8 11101110", n, seq);
        else passed++;
        @(negedge CLK); iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    endtask

    task test_write();
        @(negedge CLK); dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = BUSY;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK); #1;
            total++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'hDEADBEEF || dhit !== 1'b0)
                $display("FAIL write_busy: WEN %b REN %b addr %h store %h dhit %b, want 1 0 200 deadbeef 0", ramWEN, ramREN, ramaddr, ramstore, dhit);
            else passed++;
        end
        @(negedge CLK); ramstate = ACCESS; ramload = 32'h12345678; #1;
        total++;
        if (dhit !== 1'b1 || dload !== 32'h12345678 || ramWEN !== 1'b1)
            $display("FAIL write_hit: dhit %b dload %h WEN %b, want 1 12345678 1", dhit, dload, ramWEN);
        else passed++;
        @(negedge CLK); dWEN = 1'b0; ramstate = FREE; #1;
        total++;
        if ({dhit, ramREN, ramWEN} !== 3'b0 || ramaddr !== 0 || ramstore !== 0)
            $display("FAIL write_idle: dhit/REN/WEN %b addr %h store %h, want 0", {dhit, ramREN, ramWEN}, ramaddr, ramstore);
        else passed++;
    endtask

    task test_halt();
        logic bad;
        bad = 1'b0;
        @(negedge CLK); halt = 1'b1; iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h0BADF00D;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK); #1;
            if (ramREN !== 1'b0 || ihit !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL halt_block: fetch granted while halted, want ramREN 0");
        else passed++;
        @(negedge CLK); dREN = 1'b1; daddr = 32'h300;
        @(negedge CLK); #1;
        total++;
        if (dhit !== 1'b1 || dload !== 32'h0BADF00D || ramaddr !== 32'h300 || ihit !== 1'b0)
            $display("FAIL halt_data: dhit %b dload %h addr %h ihit %b, want 1 0badf00d 300 0", dhit, dload, ramaddr, ihit);
        else passed++;
        @(negedge CLK); dREN = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (ramREN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) bad = 1'b1;
            @(negedge CLK);
        end
        total++;
        if (bad) $display("FAIL halt_idle: strobe or hit seen while halted, want none");
        else passed++;
        halt = 1'b0; ramstate = BUSY;
        @(negedge CLK); halt = 1'b1; ramstate = ACCESS; ramload = 32'h13579BDF; #1;
        total++;
        if (ihit !== 1'b1 || iload !== 32'h13579BDF)
            $display("FAIL halt_inflight: ihit %b iload %h, want 1 13579bdf", ihit, iload);
        else passed++;
        @(negedge CLK); iREN = 1'b0; halt = 1'b0; ramstate = FREE;
    endtask

    task test_timeout();
        logic bad;
        bad = 1'b0;
        @(negedge CLK); iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK); #1;
            if (ramREN !== 1'b1 || ihit !== 1'b0 || err !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL timeout_wait: early error or hit during 16 BUSY cycles, want err 0");
        else passed++;
        @(negedge CLK); #1;
        total++;
        if (err !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0)
            $display("FAIL timeout_err: err %b ramREN %b ihit %b, want 1 0 0", err, ramREN, ihit);
        else passed++;
        ramstate = ACCESS; dREN = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); #1;
            if (err !== 1'b1 || {ihit, dhit, ramREN, ramWEN} !== 4'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL timeout_sticky: err dropped or request served in error state");
        else passed++;
        @(negedge CLK); nRST = 1'b0; #1;
        total++;
        if (err !== 1'b0 || ramREN !== 1'b0) $display("FAIL timeout_reset: err %b ramREN %b, want 0 0", err, ramREN);
        else passed++;
        @(negedge CLK); iREN = 1'b0; dREN = 1'b0; ramstate = FREE; nRST = 1'b1;
    endtask

    task test_async_reset();
        @(negedge CLK); dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        @(negedge CLK); #1;
        total++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h400) $display("FAIL areset_pre: ramREN %b addr %h, want 1 400", ramREN, ramaddr);
        else passed++;
        #1 nRST = 1'b0; ramstate = ACCESS; ramload = 32'h55AA55AA;
        #1;
        total++;
        if ({ramREN, ramWEN, dhit} !== 3'b0) $display("FAIL areset_drop: REN/WEN/dhit %b, want 000", {ramREN, ramWEN, dhit});
        else passed++;
        @(negedge CLK); nRST = 1'b1; #1;
        total++;
        if (ramREN !== 1'b0 || dhit !== 1'b0) $display("FAIL areset_idle: ramREN %b dhit %b, want 0 0", ramREN, dhit);
        else passed++;
        @(negedge CLK); #1;
        total++;
        if (dhit !== 1'b1 || dload !== 32'h55AA55AA || ramaddr !== 32'h400)
            $display("FAIL areset_regrant: dhit %b dload %h addr %h, want 1 55aa55aa 400", dhit, dload, ramaddr);
        else passed++;
        @(negedge CLK); dREN = 1'b0; ramstate = FREE;
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_priority();
        test_write();
        test_halt();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter that shares one single-ported RAM between the pipeline's instruction fetch port and data-memory port. It sits between the datapath's cache interface and the RAM. It serialises accesses with a small state machine, prioritises data over instruction with a starvation guard, and flags RAM errors and timeouts. Hits are returned to the requesting port only; the other port sees no hit.

## Interface
Parameters:
- STARVE_MAX, 3: consecutive data grants allowed while an instruction request waits.
- TIMEOUT, 15: cycles an access may wait for RAM ACCESS before error.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request (level).
- iaddr  in  32  instruction address.
- dREN  in  1  data read request (level).
- dWEN  in  1  data write request (level); dREN&dWEN is illegal, treated as write.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- halt  in  1  pipeline halted; blocks new instruction grants.
- ihit  out  1  instruction access complete.
- iload  out  32  instruction word, valid with ihit.
- dhit  out  1  data access complete.
- dload  out  32  read data, valid with dhit.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky error flag.

## Operation
- States: IDLE, DACC, IACC, ERR.
- IDLE: all RAM strobes 0, ramaddr/ramstore 0.
  - Go to DACC if a data request is present and either starve_cnt < STARVE_MAX or !iREN.
  - Otherwise go to IACC if iREN & !halt.
  - Otherwise stay in IDLE.
- DACC: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN.
  - On ramstate==ACCESS: dhit=1 and dload=ramload in the same cycle, then go to IDLE.
- IACC: ramaddr=iaddr, ramREN=1.
  - On ramstate==ACCESS: ihit=1 and iload=ramload, then go to IDLE.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments on each DACC entry taken while iREN=1, saturating at STARVE_MAX.
  - Clears on IACC entry.
  - Clears on any IDLE cycle with iREN=0.
- Requester drops its request mid-access: the RAM transaction still runs to ACCESS. The hit is suppressed; the RAM write, if any, still happens.
- ramstate==ERROR in DACC/IACC, or wait_cnt reaching TIMEOUT: go to ERR. No hit is issued.
- ERR: strobes 0, err=1, all hits 0. The state is held until reset.
- iload/dload are 0 whenever the matching hit is 0.

## Timing
- Reset: state IDLE, starve_cnt=0, wait_cnt=0, err=0. Every output is 0.
- Reset is asynchronous. Asserting nRST mid-access drops the strobes immediately; no hit is issued.
- Grant latency:
  - A request seen in IDLE at cycle n drives the RAM strobes from cycle n+1.
  - The hit comes in the first cycle from n+1 onward with ramstate==ACCESS.
  - Minimum request-to-hit is one cycle (RAM ACCESS at n+1).
- One mandatory IDLE bubble follows every completion. Back-to-back accesses therefore cost (RAM latency + 1) cycles each.
- wait_cnt:
  - Clears on entry to DACC/IACC and increments each cycle without ACCESS.
  - At wait_cnt==TIMEOUT, ERR is entered on the next edge.
- Simultaneous data and instruction requests: data wins unless starve_cnt==STARVE_MAX. In that case the instruction wins once.
- halt=1 with iREN=1 and no data request: stay in IDLE. An instruction access already in progress completes normally.

## Structure
- ramstate_t (FREE, BUSY, ACCESS, ERROR) lives in cpu_types_pkg.
- arb_state_t (IDLE, DACC, IACC, ERR) goes in diaosi_types_pkg.
- Single module. The next-state/priority logic is one always_comb; the state and counters are one always_ff.
- No sub-module is needed.

## Test plan
- Reset, then iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004 -> ihit=1 for exactly one cycle with iload=0x8C220004; dhit stays 0.
- iREN and dREN both held, daddr=0x100, RAM with 1-cycle ACCESS -> grant order D,D,D,I,D,D,D,I; each D gives dhit with dload=ramload.
- dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF until ACCESS; dhit for one cycle; then IDLE with strobes 0.
- ramstate held BUSY for 16 cycles during IACC -> err=1 after TIMEOUT and no ihit; requests afterwards are ignored until nRST pulses low.
- halt=1 with iREN=1 -> ramREN stays 0 indefinitely; a concurrent dREN is still served with dhit.
- nRST asserted during DACC -> ramREN/ramWEN go to 0 asynchronously and dhit stays 0; after release, a pending request is granted via IDLE.
